mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single 16-bit memory port between the instruction fetch path and the load/store path. Each access is serialized and held for a parameterized number of wait cycles, and completion is signalled with a one-cycle acknowledge per requester. Load/store has priority, with a starvation guard so fetch is not locked out. The arbiter sits between the pipeline stages and the memory. The fetch stage's `en` is driven from `if_ack`, and its address and data connect through `if_addr`/`if_data`.

## Interface
- `WAIT_CYCLES`, default 1: extra cycles each access holds the port. Legal range 0..7.
- `MAX_DATA_RUN`, default 4: maximum number of consecutive load/store grants while a fetch is pending. Legal range 1..15.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch requests an instruction read.
- `if_addr`  in  16  fetch address.
- `if_ack`  out  1  one-cycle completion pulse; `if_data` is valid in this cycle.
- `if_data`  out  16  read data, combinational from `mem_data`.
- `ls_req`  in  1  load/store request.
- `ls_we`  in  1  1 = store, 0 = load.
- `ls_addr`  in  16  load/store address.
- `ls_wdata`  in  16  store data.
- `ls_ack`  out  1  one-cycle completion pulse; `ls_rdata` is valid in this cycle for loads.
- `ls_rdata`  out  16  load data, combinational from `mem_data`.
- `mem_re`  out  1  memory read enable.
- `mem_we`  out  1  memory write strobe; the memory writes on the rising edge while it is high.
- `mem_addr`  out  16  memory address, driven from a register.
- `mem_wdata`  out  16  memory write data, driven from a register.
- `mem_data`  in  16  combinational read data for the current `mem_addr`.

## Operation
- FSM states:
  - IDLE: no access in progress.
  - ACCESS: an access is in progress; a wait counter `wcnt` counts down.
- Requester contract: hold `req` and all request fields stable from assertion through the `ack` cycle inclusive. In the cycle after `ack`, the requester may drop `req` or present a new request.
- IDLE with at least one `req`:
  - Choose an owner:
    - `ls` wins if `ls_req` is high and (`if_req` is low or `run_cnt` < `MAX_DATA_RUN`).
    - Otherwise `if` wins.
  - Latch owner, address, `we` (forced 0 for `if`) and `wdata` into registers.
  - Load `wcnt` = `WAIT_CYCLES` and go to ACCESS.
- IDLE with no request: stay in IDLE; `mem_re` = `mem_we` = 0.
- `run_cnt` (4-bit):
  - Increments, saturating at `MAX_DATA_RUN`, on every `ls` grant.
  - Clears to 0 on every `if` grant.
  - Also clears on an IDLE cycle with `if_req` low.
- ACCESS outputs:
  - `mem_addr` and `mem_wdata` come from the latched registers.
  - `mem_re` = !we_q throughout ACCESS.
  - `mem_we` = we_q only in the final cycle (`wcnt` == 0), giving exactly one write strobe per store.
- ACCESS progress:
  - `wcnt` != 0: decrement.
  - `wcnt` == 0: assert the owner's `ack` combinationally and return to IDLE on the next edge.
- Read data: `if_data` = `ls_rdata` = `mem_data` at all times. The data is only meaningful during the corresponding `ack`.
- Simultaneous requests: `ls` first (subject to the run limit). The losing request waits in IDLE and is evaluated again after the current access.
- `mem_addr` and `mem_wdata` keep their last values in IDLE.

## Timing
- Reset values: state IDLE, `wcnt` = 0, `run_cnt` = 0, `mem_addr` = 0, `mem_wdata` = 0, we_q = 0, owner = `if`.
- All outputs are 0 during and after reset except `if_data`/`ls_rdata`, which follow `mem_data`.
- While `rst` is high, `mem_re`, `mem_we`, `if_ack` and `ls_ack` are forced to 0 combinationally.
- Reset mid-access:
  - The access is abandoned with no `ack` and no write strobe.
  - The FSM is in IDLE on the first cycle after `rst` falls.
- Latency: a request seen in IDLE at cycle T gets its `ack` at cycle T+1+`WAIT_CYCLES`.
- Port occupancy: `WAIT_CYCLES`+2 cycles per access, including one IDLE arbitration cycle.
- `WAIT_CYCLES` = 0: ACCESS lasts one cycle; `ack` at T+1; back-to-back accesses complete every 2 cycles.
- Fetch starvation bound: with `ls_req` held continuously, a pending fetch is granted after at most `MAX_DATA_RUN` `ls` accesses.

## Test plan
- Single fetch: `WAIT_CYCLES`=1, `if_req` with `if_addr`=0x0010, memory returns 0x0BB6. Required response:
  - `mem_re` high for 2 cycles.
  - `if_ack` pulses at T+2 with `if_data`=0x0BB6.
  - `mem_we` never asserts.
- Store then load: store 0x1234 to 0x8000, then load 0x8000. Required response:
  - Exactly one `mem_we` cycle, with `mem_addr`=0x8000 and `mem_wdata`=0x1234.
  - The load's `ls_ack` returns `ls_rdata`=0x1234.
- Simultaneous requests: `if_req` and `ls_req` in the same IDLE cycle, `run_cnt`=0. Required response:
  - `ls_ack` first.
  - `if_ack` exactly `WAIT_CYCLES`+2 cycles later.
- Starvation guard: `MAX_DATA_RUN`=4, `ls_req` and `if_req` held continuously. Required response:
  - Grant sequence `ls`,`ls`,`ls`,`ls`,`if`,`ls`,….
  - Never more than 4 consecutive `ls_ack` between `if_ack` pulses.
- Reset mid-store: assert `rst` during the final ACCESS cycle of a store. Required response:
  - `mem_we` stays 0 and no `ls_ack`.
  - All registers return to their reset values.
  - A new fetch after reset completes normally.
- `WAIT_CYCLES`=0, `if_req` held continuously with a new address each `ack`. Required response: `if_ack` pulses every 2nd cycle, and each `if_data` matches its address.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
//
// Shares one 16-bit memory port between instruction fetch (if_*) and load/store
// (ls_*). Each access is latched in an IDLE arbitration cycle and then holds the
// port for WAIT_CYCLES+1 ACCESS cycles. The final ACCESS cycle raises the
// owner's one-cycle ack and, for stores, the single memory write strobe.
// Load/store wins arbitration, but only MAX_DATA_RUN times in a row while a
// fetch is waiting.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   if_req, if_addr      fetch request and address
//   if_ack, if_data      fetch completion pulse and read data
//   ls_req, ls_we,       load/store request, store select, address, store data
//   ls_addr, ls_wdata
//   ls_ack, ls_rdata     load/store completion pulse and load data
//   mem_re, mem_we       memory read enable / write strobe
//   mem_addr, mem_wdata  registered memory address / write data
//   mem_data             combinational memory read data
module mem_port_arbiter #(
    parameter int unsigned WAIT_CYCLES  = 1,
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_ack,
    output logic [15:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [15:0] ls_addr,
    input  logic [15:0] ls_wdata,
    output logic        ls_ack,
    output logic [15:0] ls_rdata,
    output logic        mem_re,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_data
);

    localparam logic [2:0] WaitInit = 3'(WAIT_CYCLES);
    localparam logic [3:0] RunMax   = 4'(MAX_DATA_RUN);

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } state_e;

    state_e      state_q;
    logic [2:0]  wcnt_q;
    logic [3:0]  run_cnt_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        we_q;
    logic        owner_ls_q;

    logic ls_win;
    logic last_cycle;

    // Load/store wins unless a fetch is waiting and the run limit is reached.
    assign ls_win     = ls_req && (!if_req || (run_cnt_q < RunMax));
    assign last_cycle = (state_q == StAccess) && (wcnt_q == 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wcnt_q     <= 3'd0;
            run_cnt_q  <= 4'd0;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            we_q       <= 1'b0;
            owner_ls_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ls_win) begin
                        owner_ls_q <= 1'b1;
                        addr_q     <= ls_addr;
                        we_q       <= ls_we;
                        wdata_q    <= ls_wdata;
                        wcnt_q     <= WaitInit;
                        state_q    <= StAccess;
                    end else if (if_req) begin
                        owner_ls_q <= 1'b0;
                        addr_q     <= if_addr;
                        we_q       <= 1'b0;
                        wcnt_q     <= WaitInit;
                        state_q    <= StAccess;
                    end
                    // The run only counts load/store grants made while a fetch
                    // is waiting; with no fetch pending it stays cleared.
                    if (!if_req) begin
                        run_cnt_q <= 4'd0;
                    end else if (ls_win) begin
                        if (run_cnt_q < RunMax) begin
                            run_cnt_q <= run_cnt_q + 4'd1;
                        end
                    end else begin
                        run_cnt_q <= 4'd0;
                    end
                end
                StAccess: begin
                    if (wcnt_q != 3'd0) begin
                        wcnt_q <= wcnt_q - 3'd1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Strobes are gated by rst so an access interrupted by reset never acks
    // or writes.
    always_comb begin
        mem_re = 1'b0;
        mem_we = 1'b0;
        if_ack = 1'b0;
        ls_ack = 1'b0;
        if (!rst && (state_q == StAccess)) begin
            mem_re = !we_q;
            mem_we = we_q && last_cycle;
            if_ack = last_cycle && !owner_ls_q;
            ls_ack = last_cycle && owner_ls_q;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_data   = mem_data;
    assign ls_rdata  = mem_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int unsigned W      = 1;
    localparam int unsigned MaxRun = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
    logic [15:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
    logic        if_ack, ls_ack, mem_re, mem_we;
    logic [15:0] if_data, ls_rdata, mem_addr, mem_wdata, mem_data;

    // Second instance with zero wait cycles, fetch-only.
    logic        z_if_req = 1'b0;
    logic [15:0] z_if_addr = '0;
    logic        z_if_ack, z_ls_ack, z_mem_re, z_mem_we;
    logic [15:0] z_if_data, z_ls_rdata, z_mem_addr, z_mem_wdata, z_mem_data;

    int n_vec = 0;
    int n_err = 0;

    mem_port_arbiter #(.WAIT_CYCLES(W), .MAX_DATA_RUN(MaxRun)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_data(mem_data)
    );

    mem_port_arbiter #(.WAIT_CYCLES(0), .MAX_DATA_RUN(MaxRun)) u_dut0 (
        .clk(clk), .rst(rst),
        .if_req(z_if_req), .if_addr(z_if_addr), .if_ack(z_if_ack), .if_data(z_if_data),
        .ls_req(1'b0), .ls_we(1'b0), .ls_addr(16'h0000), .ls_wdata(16'h0000),
        .ls_ack(z_ls_ack), .ls_rdata(z_ls_rdata),
        .mem_re(z_mem_re), .mem_we(z_mem_we), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_data(z_mem_data)
    );

    // Memory: unwritten words read as addr ^ 16'h0BA6.
    logic [15:0] mem [0:65535];
    assign mem_data   = mem[mem_addr];
    assign z_mem_data = z_mem_addr ^ 16'h0BA6;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h0BA6;
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_addr] <= mem_wdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst, fr;
        logic [15:0] fa;
        logic        lr, lw;
        logic [15:0] la, ld;
        logic        re, we, fk, lk;
        logic [15:0] addr, data;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic fr, input logic [15:0] fa,
                                input logic lr, input logic lw, input logic [15:0] la,
                                input logic [15:0] ld, input logic re, input logic we,
                                input logic fk, input logic lk, input logic [15:0] addr,
                                input logic [15:0] data);
        vec_t v;
        v.rst = r; v.fr = fr; v.fa = fa; v.lr = lr; v.lw = lw; v.la = la; v.ld = ld;
        v.re = re; v.we = we; v.fk = fk; v.lk = lk; v.addr = addr; v.data = data;
        return v;
    endfunction

    vec_t vt [20];

    // Reference model state: an access is a (owner, address, completion cycle) record.
    bit          m_busy, m_we, m_own_ls;
    int          m_done_cyc, cyc;
    int unsigned m_run;
    logic [15:0] m_addr, m_wdata;
    logic [15:0] shadow [0:65535];

    initial begin
        logic        b0, b1;
        int          k, last;
        bit          got, prev_if_ack, prev_ls_ack, if_act, ls_act, l_win, e_done;

        b0 = 1'b0;
        b1 = 1'b1;
        // rst fr fa  lr lw la  ld | re we fk lk addr data
        vt[0]  = mk(b1, b0, 16'h0,    b0, b0, 16'h0,    16'h0,    b0, b0, b0, b0, 16'h0000, 16'h0);
        vt[1]  = mk(b1, b0, 16'h0,    b0, b0, 16'h0,    16'h0,    b0, b0, b0, b0, 16'h0000, 16'h0);
        vt[2]  = mk(b0, b0, 16'h0,    b0, b0, 16'h0,    16'h0,    b0, b0, b0, b0, 16'h0000, 16'h0);
        vt[3]  = mk(b0, b1, 16'h0010, b0, b0, 16'h0,    16'h0,    b0, b0, b0, b0, 16'h0000, 16'h0);
        vt[4]  = mk(b0, b1, 16'h0010, b0, b0, 16'h0,    16'h0,    b1, b0, b0, b0, 16'h0010, 16'h0);
        vt[5]  = mk(b0, b1, 16'h0010, b0, b0, 16'h0,    16'h0,    b1, b0, b1, b0, 16'h0010, 16'h0BB6);
        vt[6]  = mk(b0, b0, 16'h0,    b0, b0, 16'h0,    16'h0,    b0, b0, b0, b0, 16'h0010, 16'h0);
        vt[7]  = mk(b0, b0, 16'h0,    b1, b1, 16'h8000, 16'h1234, b0, b0, b0, b0, 16'h0010, 16'h0);
        vt[8]  = mk(b0, b0, 16'h0,    b1, b1, 16'h8000, 16'h1234, b0, b0, b0, b0, 16'h8000, 16'h0);
        vt[9]  = mk(b0, b0, 16'h0,    b1, b1, 16'h8000, 16'h1234, b0, b1, b0, b1, 16'h8000, 16'h1234);
        vt[10] = mk(b0, b0, 16'h0,    b1, b0, 16'h8000, 16'h0,    b0, b0, b0, b0, 16'h8000, 16'h0);
        vt[11] = mk(b0, b0, 16'h0,    b1, b0, 16'h8000, 16'h0,    b1, b0, b0, b0, 16'h8000, 16'h0);
        vt[12] = mk(b0, b0, 16'h0,    b1, b0, 16'h8000, 16'h0,    b1, b0, b0, b1, 16'h8000, 16'h1234);
        vt[13] = mk(b0, b1, 16'h0020, b1, b0, 16'h0030, 16'h0,    b0, b0, b0, b0, 16'h8000, 16'h0);
        vt[14] = mk(b0, b1, 16'h0020, b1, b0, 16'h0030, 16'h0,    b1, b0, b0, b0, 16'h0030, 16'h0);
        vt[15] = mk(b0, b1, 16'h0020, b1, b0, 16'h0030, 16'h0,    b1, b0, b0, b1, 16'h0030, 16'h0B96);
        vt[16] = mk(b0, b1, 16'h0020, b0, b0, 16'h0,    16'h0,    b0, b0, b0, b0, 16'h0030, 16'h0);
        vt[17] = mk(b0, b1, 16'h0020, b0, b0, 16'h0,    16'h0,    b1, b0, b0, b0, 16'h0020, 16'h0);
        vt[18] = mk(b0, b1, 16'h0020, b0, b0, 16'h0,    16'h0,    b1, b0, b1, b0, 16'h0020, 16'h0B86);
        vt[19] = mk(b0, b0, 16'h0,    b0, b0, 16'h0,    16'h0,    b0, b0, b0, b0, 16'h0020, 16'h0);

        // Directed table: reset, single fetch, store then load, simultaneous requests.
        for (int i = 0; i < 20; i++) begin
            rst = vt[i].rst; if_req = vt[i].fr; if_addr = vt[i].fa;
            ls_req = vt[i].lr; ls_we = vt[i].lw; ls_addr = vt[i].la; ls_wdata = vt[i].ld;
            @(negedge clk);
            chk1($sformatf("row%0d mem_re", i), mem_re, vt[i].re);
            chk1($sformatf("row%0d mem_we", i), mem_we, vt[i].we);
            chk1($sformatf("row%0d if_ack", i), if_ack, vt[i].fk);
            chk1($sformatf("row%0d ls_ack", i), ls_ack, vt[i].lk);
            chk16($sformatf("row%0d mem_addr", i), mem_addr, vt[i].addr);
            if (vt[i].fk) chk16($sformatf("row%0d if_data", i), if_data, vt[i].data);
            if (vt[i].lk && !vt[i].lw) chk16($sformatf("row%0d ls_rdata", i), ls_rdata, vt[i].data);
            if (vt[i].we) chk16($sformatf("row%0d mem_wdata", i), mem_wdata, vt[i].data);
            next_cycle();
        end

        // Starvation guard: both held, grants must go ls x4, if, repeating.
        if_req = 1'b1; if_addr = 16'h0050;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0060;
        k = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (if_ack || ls_ack) begin
                chk1($sformatf("starve%0d both acks", k), if_ack && ls_ack, 1'b0);
                chk1($sformatf("starve%0d if_ack", k), if_ack, (k % 5) == 4);
                k++;
            end
            next_cycle();
        end
        chk16("starve ack count", 16'(k), 16'd15);
        if_req = 1'b0; ls_req = 1'b0;
        next_cycle();

        // Reset during the final cycle of a store.
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h4000; ls_wdata = 16'hBEEF;
        next_cycle();
        @(negedge clk);
        chk16("rststore access addr", mem_addr, 16'h4000);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk1("rststore mem_we", mem_we, 1'b0);
        chk1("rststore ls_ack", ls_ack, 1'b0);
        chk1("rststore mem_re", mem_re, 1'b0);
        next_cycle();
        rst = 1'b0; ls_req = 1'b0; ls_we = 1'b0; if_req = 1'b1; if_addr = 16'h0040;
        @(negedge clk);
        chk16("rststore addr reset", mem_addr, 16'h0000);
        chk16("rststore mem intact", mem[16'h4000], 16'h4000 ^ 16'h0BA6);
        chk1("rststore idle re", mem_re, 1'b0);
        next_cycle();
        @(negedge clk);
        chk1("rstfetch re", mem_re, 1'b1);
        chk1("rstfetch early ack", if_ack, 1'b0);
        chk16("rstfetch addr", mem_addr, 16'h0040);
        next_cycle();
        @(negedge clk);
        chk1("rstfetch if_ack", if_ack, 1'b1);
        chk16("rstfetch if_data", if_data, 16'h0BE6);
        next_cycle();
        if_req = 1'b0;
        next_cycle();

        // Zero wait cycles: back-to-back fetches ack every 2nd cycle.
        z_if_req = 1'b1; z_if_addr = 16'h0200;
        k = 0; last = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            got = z_if_ack;
            if (got) begin
                chk16($sformatf("w0 ack%0d data", k), z_if_data, z_if_addr ^ 16'h0BA6);
                chk16($sformatf("w0 ack%0d spacing", k), 16'(c - last), (k == 0) ? 16'd1 : 16'd2);
                last = c;
                k++;
            end
            next_cycle();
            if (got) z_if_addr = z_if_addr + 16'h0011;
        end
        chk16("w0 ack count", 16'(k), 16'd15);
        z_if_req = 1'b0;

        // Randomized traffic against a transaction-level model.
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 65536; i++) shadow[i] = mem[i];
        m_busy = 0; m_we = 0; m_own_ls = 0; m_done_cyc = 0; m_run = 0;
        m_addr = 16'h0000; m_wdata = 16'h0000;
        prev_if_ack = 0; prev_ls_ack = 0; if_act = 0; ls_act = 0;
        for (cyc = 0; cyc < 600; cyc++) begin
            if (prev_if_ack) if_act = 0;
            if (prev_ls_ack) ls_act = 0;
            if (!if_act && $urandom_range(0, 2) != 0) begin
                if_act = 1;
                if_addr = 16'h0100 + 16'($urandom_range(0, 7));
            end
            if (!ls_act && $urandom_range(0, 2) != 0) begin
                ls_act = 1;
                ls_we = 1'($urandom_range(0, 1));
                ls_addr = 16'h0100 + 16'($urandom_range(0, 7));
                ls_wdata = 16'($urandom);
            end
            if_req = if_act;
            ls_req = ls_act;
            @(negedge clk);
            e_done = m_busy && (cyc == m_done_cyc);
            chk1($sformatf("rnd%0d mem_re", cyc), mem_re, m_busy && !m_we);
            chk1($sformatf("rnd%0d mem_we", cyc), mem_we, e_done && m_we);
            chk1($sformatf("rnd%0d if_ack", cyc), if_ack, e_done && !m_own_ls);
            chk1($sformatf("rnd%0d ls_ack", cyc), ls_ack, e_done && m_own_ls);
            chk16($sformatf("rnd%0d mem_addr", cyc), mem_addr, m_addr);
            if (e_done && m_we) chk16($sformatf("rnd%0d mem_wdata", cyc), mem_wdata, m_wdata);
            if (e_done && !m_own_ls) chk16($sformatf("rnd%0d if_data", cyc), if_data, shadow[m_addr]);
            if (e_done && m_own_ls && !m_we)
                chk16($sformatf("rnd%0d ls_rdata", cyc), ls_rdata, shadow[m_addr]);
            prev_if_ack = if_ack;
            prev_ls_ack = ls_ack;
            // Model update for the coming edge.
            if (m_busy) begin
                if (e_done) begin
                    m_busy = 0;
                    if (m_we) shadow[m_addr] = m_wdata;
                end
            end else begin
                l_win = ls_req && (!if_req || m_run < MaxRun);
                if (l_win) begin
                    m_run = if_req ? ((m_run < MaxRun) ? m_run + 1 : m_run) : 0;
                    m_busy = 1; m_own_ls = 1; m_we = ls_we;
                    m_addr = ls_addr; m_wdata = ls_wdata;
                    m_done_cyc = cyc + 1 + int'(W);
                end else if (if_req) begin
                    m_run = 0;
                    m_busy = 1; m_own_ls = 0; m_we = 0;
                    m_addr = if_addr;
                    m_done_cyc = cyc + 1 + int'(W);
                end else begin
                    m_run = 0;
                end
            end
            next_cycle();
        end
        if_req = 1'b0;
        ls_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
